// File: rtl/pwm_capture.sv
// PWM input capture: measures rise-to-rise period and high time of an asynchronous
// PWM line, derives duty in percent with a 7-step divider, and flags a stuck line.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic [6:0]       duty_pct,
  output logic             duty_valid,
  output logic             timeout
);

  localparam int                RW  = CNT_W + 7;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sync_q;
  logic             pwm_s, pwm_d, rise, fall;
  logic [CNT_W-1:0] cnt_per, cnt_hi, hi_lat;
  logic             capture, tmo_hit;

  logic             div_busy, div_fin;
  logic [2:0]       bit_idx;
  logic [RW-1:0]    rem, den_sh;
  logic [CNT_W-1:0] den;
  logic [6:0]       q;

  assign pwm_s = sync_q[1];
  assign pwm_d = sync_q[2];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  // NOTE: clocked state always uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[1:0], pwm_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEEK;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    // Once a stuck line is flagged in SEEK the saturated counter must not re-fire.
    tmo_hit   = !rise && (cnt_per == TMO) && ((state != SEEK) || !timeout);
    case (state)
      SEEK: if (rise) state_nxt = HIGH;
      HIGH: if (fall) state_nxt = LOW;
      LOW: begin
        if (rise) begin
          capture   = 1'b1;
          state_nxt = HIGH;
        end
      end
      default: state_nxt = SEEK;
    endcase
    if (tmo_hit) state_nxt = SEEK;
  end

  // Period counter runs in every state and saturates at the timeout threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_per <= '0;
      cnt_hi  <= '0;
      hi_lat  <= '0;
    end else begin
      if (rise) begin
        cnt_per <= CNT_W'(1);
        cnt_hi  <= CNT_W'(1);
      end else begin
        if (cnt_per != TMO)             cnt_per <= cnt_per + CNT_W'(1);
        if ((state == HIGH) && !fall)   cnt_hi  <= cnt_hi + CNT_W'(1);
      end
      if ((state == HIGH) && fall) hi_lat <= cnt_hi;
    end
  end

  assign den_sh = RW'(den) << bit_idx;

  // Restoring divider: one quotient bit per cycle, MSB (weight 64) first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy <= 1'b0;
      div_fin  <= 1'b0;
      bit_idx  <= '0;
      rem      <= '0;
      den      <= '0;
      q        <= '0;
    end else begin
      div_fin <= 1'b0;
      if (tmo_hit) begin
        div_busy <= 1'b0;
      end else if (div_busy) begin
        if (rem >= den_sh) begin
          rem        <= rem - den_sh;
          q[bit_idx] <= 1'b1;
        end
        if (bit_idx == 3'd0) begin
          div_busy <= 1'b0;
          div_fin  <= 1'b1;
        end else begin
          bit_idx <= bit_idx - 3'd1;
        end
      end else if (capture && !div_fin) begin
        rem      <= RW'(hi_lat) * RW'(7'd100);
        den      <= cnt_per;
        q        <= '0;
        bit_idx  <= 3'd6;
        div_busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid      <= capture;
      duty_valid <= 1'b0;
      if (capture) begin
        period_out <= cnt_per;
        high_out   <= hi_lat;
        timeout    <= 1'b0;
      end else if (tmo_hit) begin
        period_out <= '0;
        high_out   <= '0;
        timeout    <= 1'b1;
      end
      if (tmo_hit) begin
        duty_pct   <= pwm_s ? 7'd100 : 7'd0;
        duty_valid <= 1'b1;
      end else if (div_fin) begin
        duty_pct   <= q;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM trains, logs valid/duty/timeout events
// from a negedge monitor, and compares them with hand-computed values.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_out, high_out;
  logic             valid, duty_valid, timeout;
  logic [6:0]       duty_pct;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .duty_pct  (duty_pct),
    .duty_valid(duty_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int per; int hi;} vrec_t;
  typedef struct {int cyc; int duty;} drec_t;

  vrec_t vq[$];
  drec_t dq[$];
  int    tq[$];
  int    cyc = 0;
  logic  tmo_prev = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (valid)                 vq.push_back('{cyc, int'(period_out), int'(high_out)});
      if (duty_valid)            dq.push_back('{cyc, int'(duty_pct)});
      if (timeout && !tmo_prev)  tq.push_back(cyc);
    end
    tmo_prev <= timeout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int v_per(input int i);  return (i < vq.size()) ? vq[i].per  : -1; endfunction
  function automatic int v_hi(input int i);   return (i < vq.size()) ? vq[i].hi   : -1; endfunction
  function automatic int v_cyc(input int i);  return (i < vq.size()) ? vq[i].cyc  : -1; endfunction
  function automatic int d_duty(input int i); return (i < dq.size()) ? dq[i].duty : -1; endfunction
  function automatic int d_cyc(input int i);  return (i < dq.size()) ? dq[i].cyc  : -1; endfunction
  function automatic int t_cyc(input int i);  return (i < tq.size()) ? tq[i]      : -1; endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b0;
    pwm_in = 1'b0;
    vq.delete();
    dq.delete();
    tq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pwm_cycle(input int hi, input int lo);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Closing rise that captures the last driven cycle, held long enough for the duty result.
  task automatic final_rise(input int hold);
    pwm_in = 1'b1;
    repeat (hold) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic single_duty(input string tag, input int hi, input int per, input int duty);
    apply_reset();
    pwm_cycle(hi, per - hi);
    final_rise(12);
    check({tag, "_nvalid"}, vq.size(), 1);
    check({tag, "_period"}, v_per(0), per);
    check({tag, "_high"},   v_hi(0), hi);
    check({tag, "_duty"},   d_duty(0), duty);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_valid", valid, 0);
    check("rst_duty", duty_pct, 0);
    check("rst_duty_valid", duty_valid, 0);
    check("rst_timeout", timeout, 0);

    // 25/100 train: first rise arms, following rises capture
    apply_reset();
    repeat (2) pwm_cycle(25, 75);
    final_rise(12);
    check("c25_nvalid", vq.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check("c25_period", v_per(i), 100);
      check("c25_high", v_hi(i), 25);
      check("c25_duty", d_duty(i), 25);
    end
    check("c25_duty_latency", d_cyc(0) - v_cyc(0), 8);

    // Rounding toward zero
    single_duty("r1_3", 1, 3, 33);
    single_duty("r2_3", 2, 3, 66);
    single_duty("r99_100", 99, 100, 99);

    // Generator loop-back ramp over period 101
    apply_reset();
    for (int h = 5; h <= 100; h += 5) pwm_cycle(h, 101 - h);
    final_rise(12);
    check("ramp_nvalid", vq.size(), 20);
    check("ramp_nduty", dq.size(), 20);
    for (int k = 0; k < 20; k++) begin
      check("ramp_period", v_per(k), 101);
      check("ramp_high", v_hi(k), (k + 1) * 5);
      check("ramp_duty", d_duty(k), ((k + 1) * 5 * 100) / 101);
    end

    // Line stuck high after a capture
    apply_reset();
    pwm_cycle(25, 75);
    pwm_in = 1'b1;
    repeat (260) @(negedge clk);
    check("toh_ntmo", tq.size(), 1);
    check("toh_delay", t_cyc(0) - v_cyc(0), TMO);
    check("toh_flag", timeout, 1);
    check("toh_period", period_out, 0);
    check("toh_high", high_out, 0);
    check("toh_duty", duty_pct, 100);
    check("toh_nduty", dq.size(), 2);
    check("toh_dv_cyc", d_cyc(1), t_cyc(0));
    check("toh_dv_duty", d_duty(1), 100);
    repeat (300) @(negedge clk);
    check("toh_no_refire", dq.size(), 2);
    check("toh_still", timeout, 1);

    // Line stuck low after a capture, then resume
    apply_reset();
    pwm_cycle(25, 75);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    repeat (250) @(negedge clk);
    check("tol_ntmo", tq.size(), 1);
    check("tol_delay", t_cyc(0) - v_cyc(0), TMO);
    check("tol_flag", timeout, 1);
    check("tol_duty", duty_pct, 0);
    pwm_cycle(25, 75);
    check("res_arm_only", vq.size(), 1);
    check("res_tmo_held", timeout, 1);
    final_rise(12);
    check("res_nvalid", vq.size(), 2);
    check("res_period", v_per(1), 100);
    check("res_high", v_hi(1), 25);
    check("res_tmo_clr", timeout, 0);

    // Short period 1/4: divider busy drops intermediate captures
    apply_reset();
    repeat (8) pwm_cycle(1, 3);
    final_rise(16);
    check("sp_nvalid", vq.size(), 8);
    for (int i = 1; i < 8; i++) check("sp_spacing", v_cyc(i) - v_cyc(i - 1), 4);
    for (int i = 0; i < 8; i++) begin
      check("sp_period", v_per(i), 4);
      check("sp_high", v_hi(i), 1);
    end
    check("sp_nduty", dq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("sp_duty", d_duty(k), 25);
      check("sp_duty_cyc", d_cyc(k), v_cyc(3 * k) + 8);
    end

    // Asynchronous reset mid-HIGH
    apply_reset();
    pwm_cycle(25, 75);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    check("mr_pre_period", period_out, 100);
    #2 rst = 1'b0;
    #1;
    check("mr_period", period_out, 0);
    check("mr_high", high_out, 0);
    check("mr_valid", valid, 0);
    check("mr_duty", duty_pct, 0);
    check("mr_duty_valid", duty_valid, 0);
    check("mr_timeout", timeout, 0);
    @(negedge clk);
    vq.delete();
    dq.delete();
    tq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (80) @(negedge clk);
    check("mr_arm_only", vq.size(), 0);
    final_rise(12);
    check("mr_nvalid", vq.size(), 1);
    check("mr_cap_period", v_per(0), 100);
    check("mr_cap_high", v_hi(0), 20);
    check("mr_cap_duty", d_duty(0), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
